// File: rtl/count_event_monitor_if.sv
// Event-record stream from count_event_monitor to its logging consumer.
// The master drives the show-ahead head record and valid; the slave drives ready.
interface count_event_monitor_if #(
  parameter int CNT_W = 4,
  parameter int TS_W  = 16
);
  logic             evt_valid;
  logic             evt_ready;
  logic [1:0]       evt_code;
  logic [CNT_W-1:0] evt_count;
  logic [TS_W-1:0]  evt_time;

  modport master (
    output evt_valid,
    output evt_code,
    output evt_count,
    output evt_time,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_code,
    input  evt_count,
    input  evt_time,
    output evt_ready
  );
endinterface

// File: rtl/count_event_monitor.sv
// Observes an enable-gated up-counter and reports start/stop/wrap/error events.
// Each event is timestamped and queued in a show-ahead FIFO with a sticky overflow flag.
module count_event_monitor #(
  parameter  int CNT_W = 4,
  parameter  int TS_W  = 16,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [CNT_W-1:0]       count_in,
  input  logic                   enable_in,
  input  logic                   clear_ovf,
  count_event_monitor_if.master  evt,
  output logic [AW:0]            evt_level,
  output logic                   overflow
);

  typedef enum logic [1:0] {
    EV_START = 2'd0,
    EV_STOP  = 2'd1,
    EV_WRAP  = 2'd2,
    EV_ERROR = 2'd3
  } evt_code_e;

  typedef struct packed {
    evt_code_e        code;
    logic [CNT_W-1:0] cnt;
    logic [TS_W-1:0]  ts;
  } rec_t;

  rec_t             mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      level;
  logic [TS_W-1:0]  ts;
  logic [CNT_W-1:0] prev_count;
  logic             prev_en;
  logic             primed;

  logic [CNT_W-1:0] cnt_inc;
  logic             det;
  evt_code_e        det_code;
  logic             full, pop, push, drop;
  rec_t             head;

  assign cnt_inc = prev_count + CNT_W'(1);

  // Priority chain: an ERROR masks everything; WRAP masks the STOP it may coincide with.
  always_comb begin
    det      = 1'b0;
    det_code = EV_START;
    if (primed) begin
      if (prev_en ? (count_in != cnt_inc) : (count_in != prev_count)) begin
        det      = 1'b1;
        det_code = EV_ERROR;
      end else if (prev_en && (prev_count == '1) && (count_in == '0)) begin
        det      = 1'b1;
        det_code = EV_WRAP;
      end else if (enable_in && !prev_en) begin
        det      = 1'b1;
        det_code = EV_START;
      end else if (!enable_in && prev_en) begin
        det      = 1'b1;
        det_code = EV_STOP;
      end
    end
  end

  assign full = (level == (AW+1)'(DEPTH));
  assign pop  = evt.evt_valid && evt.evt_ready;
  assign push = det && (!full || pop);
  assign drop = det && full && !pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ts         <= '0;
      prev_count <= '0;
      prev_en    <= 1'b0;
      primed     <= 1'b0;
    end else begin
      ts         <= ts + TS_W'(1);
      prev_count <= count_in;
      prev_en    <= enable_in;
      primed     <= 1'b1;
    end
  end

  // Storage is reset too so the head fields read zero while in reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i[AW-1:0]] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{code: det_code, cnt: count_in, ts: ts};
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      level <= level + (AW+1)'(1);
      else if (!push && pop) level <= level - (AW+1)'(1);
      if (drop)           overflow <= 1'b1;
      else if (clear_ovf) overflow <= 1'b0;
    end
  end

  assign head          = mem[rd_ptr];
  assign evt.evt_valid = (level != '0);
  assign evt.evt_code  = head.code;
  assign evt.evt_count = head.cnt;
  assign evt.evt_time  = head.ts;
  assign evt_level     = level;

endmodule

// File: tb/tb_count_event_monitor.sv
// Directed bench for count_event_monitor: drives count/enable vectors edge by edge
// and compares the queued records against hand-derived expectations.
module tb_count_event_monitor;

  logic       clk;
  logic       rst;
  logic [3:0] count_in;
  logic       enable_in;
  logic       clear_ovf;
  logic [2:0] evt_level;
  logic       overflow;

  int unsigned checks;
  int unsigned errors;
  int unsigned edge_n;
  int unsigned last_t;
  int unsigned spur;
  int unsigned t_first;

  count_event_monitor_if #(.CNT_W(4), .TS_W(16)) evt_if ();

  count_event_monitor #(.CNT_W(4), .TS_W(16), .DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .count_in  (count_in),
    .enable_in (enable_in),
    .clear_ovf (clear_ovf),
    .evt       (evt_if),
    .evt_level (evt_level),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    edge_n++;
    #1;
  endtask

  // Apply one input vector; last_t is the timestamp the DUT sees on that edge.
  task automatic drive(input logic en, input logic [3:0] c);
    enable_in = en;
    count_in  = c;
    last_t    = edge_n;
    tick();
  endtask

  initial begin
    checks = 0; errors = 0; edge_n = 0; spur = 0;
    rst = 1'b0; count_in = '0; enable_in = 1'b0; clear_ovf = 1'b0;
    evt_if.evt_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", evt_if.evt_valid, 0);
    check("rst_code",  evt_if.evt_code,  0);
    check("rst_count", evt_if.evt_count, 0);
    check("rst_time",  evt_if.evt_time,  0);
    check("rst_level", evt_level,        0);
    check("rst_ovf",   overflow,         0);

    @(negedge clk);
    rst = 1'b1;
    edge_n = 0;
    evt_if.evt_ready = 1'b1;

    drive(0, 0);
    drive(0, 0);
    check("idle_valid", evt_if.evt_valid, 0);

    drive(1, 0);
    check("start_valid", evt_if.evt_valid, 1);
    check("start_code",  evt_if.evt_code,  0);
    check("start_count", evt_if.evt_count, 0);
    check("start_time",  evt_if.evt_time,  2);
    check("start_level", evt_level,        1);

    for (int c = 1; c < 16; c++) begin
      drive(1, 4'(c));
      if (evt_if.evt_valid) spur++;
    end
    check("run_spurious", spur, 0);

    drive(1, 0);
    check("wrap_code",  evt_if.evt_code,  2);
    check("wrap_count", evt_if.evt_count, 0);
    check("wrap_time",  evt_if.evt_time,  18);

    drive(0, 1);
    check("stop_code",  evt_if.evt_code,  1);
    check("stop_count", evt_if.evt_count, 1);
    check("stop_time",  evt_if.evt_time,  19);
    check("pushpop_level", evt_level, 1);

    drive(0, 1);
    check("stop_drained", evt_if.evt_valid, 0);

    drive(1, 1);
    check("start2_code", evt_if.evt_code, 0);
    drive(1, 2); drive(1, 3); drive(1, 4); drive(1, 5);
    drive(1, 5);
    check("stall_code",  evt_if.evt_code,  3);
    check("stall_count", evt_if.evt_count, 5);
    drive(1, 6);
    check("resume_quiet", evt_if.evt_valid, 0);
    drive(0, 7);
    check("stop2_code",  evt_if.evt_code,  1);
    check("stop2_count", evt_if.evt_count, 7);
    drive(0, 7);
    drive(0, 8);
    check("spur_code",  evt_if.evt_code,  3);
    check("spur_count", evt_if.evt_count, 8);
    drive(0, 8);

    drive(1, 8);
    for (int c = 9; c < 16; c++) drive(1, 4'(c));
    drive(0, 0);
    check("wrapstop_code",  evt_if.evt_code,  2);
    check("wrapstop_count", evt_if.evt_count, 0);
    drive(0, 0);
    check("wrapstop_nostop", evt_if.evt_valid, 0);

    evt_if.evt_ready = 1'b0;
    drive(0, 1);
    t_first = last_t;
    drive(0, 2); drive(0, 3); drive(0, 4); drive(0, 5);
    check("full_level", evt_level,        4);
    check("full_ovf",   overflow,         1);
    check("full_code",  evt_if.evt_code,  3);
    check("full_count", evt_if.evt_count, 1);
    check("full_time",  evt_if.evt_time,  t_first);

    clear_ovf = 1'b1;
    drive(0, 6);
    check("setwins_ovf",   overflow,  1);
    check("setwins_level", evt_level, 4);
    drive(0, 6);
    check("clear_ovf", overflow, 0);
    clear_ovf = 1'b0;

    evt_if.evt_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      check("drain_count", evt_if.evt_count, k);
      check("drain_level", evt_level, 5 - k);
      drive(0, 6);
    end
    check("drain_empty", evt_level, 0);
    check("drain_valid", evt_if.evt_valid, 0);

    evt_if.evt_ready = 1'b0;
    drive(0, 7);
    drive(0, 8);
    check("pre_rst_level", evt_level, 2);
    #3;
    rst = 1'b0;
    #1;
    check("async_valid", evt_if.evt_valid, 0);
    check("async_level", evt_level,        0);
    check("async_ovf",   overflow,         0);
    check("async_count", evt_if.evt_count, 0);

    @(negedge clk);
    rst = 1'b1;
    edge_n = 0;
    drive(0, 12);
    check("prime_quiet", evt_if.evt_valid, 0);
    drive(0, 12);
    drive(1, 12);
    check("post_rst_code", evt_if.evt_code, 0);
    check("post_rst_time", evt_if.evt_time, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/count_event_monitor.md
Name: count_event_monitor

Overview:
- Downstream observer for the enable-gated up-counter (clk, rst, enable, count) used in the timing-characterisation test modules.
- Samples the counter's enable and count every cycle, detects counting start/stop, wrap-around and illegal count transitions, and timestamps each event.
- Buffers event records in a small FIFO with a valid/ready output, for the logging/feature-extraction stage feeding the timing-violation predictor.

Parameters:
- CNT_W, 4, width of the observed count.
- TS_W, 16, width of the free-running timestamp.
- DEPTH, 4, FIFO entries; must be a power of 2 and at least 2.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- count_in  in  CNT_W  count output of the observed counter.
- enable_in  in  1  enable driven into the observed counter.
- evt_ready  in  1  consumer accepts the head record.
- clear_ovf  in  1  synchronous clear of overflow.
- evt_valid  out  1  FIFO non-empty; head record valid.
- evt_code  out  2  head event code: 0 START, 1 STOP, 2 WRAP, 3 ERROR.
- evt_count  out  CNT_W  count_in value in the cycle the event was detected.
- evt_time  out  TS_W  timestamp of the detection cycle.
- evt_level  out  $clog2(DEPTH)+1  entries currently stored.
- overflow  out  1  sticky flag: an event was dropped because the FIFO was full.

Behaviour:
- Reset (rst=0, asynchronous):
  - All outputs are 0: evt_valid, evt_code, evt_count, evt_time, evt_level and overflow.
  - FIFO pointers, timestamp, prev_count, prev_en and primed are cleared.
  - Reset mid-operation discards all stored records immediately, without waiting for a clock edge.
- Timestamp:
  - ts increments by 1 every clock after reset release and wraps modulo 2^TS_W.
  - The first active edge after release sees ts=0.
- History registers:
  - prev_count and prev_en load count_in and enable_in every edge.
  - primed sets on the first edge after reset release.
  - No event is detected while primed=0.
- Detection (combinational on the current inputs vs. history, evaluated when primed=1):
  - START: enable_in=1 and prev_en=0.
  - STOP: enable_in=0 and prev_en=1.
  - WRAP: prev_en=1, prev_count=2^CNT_W-1 and count_in=0.
  - ERROR, case 1: prev_en=1 and count_in != prev_count+1 (mod 2^CNT_W). This covers a stall or a skip.
  - ERROR, case 2: prev_en=0 and count_in != prev_count. This is a spurious change.
- One record per cycle:
  - Priority is ERROR > WRAP > START > STOP.
  - Lower-priority coincident events are discarded and are not counted.
  - Only WRAP+STOP and ERROR+any can coincide.
- Record push:
  - The record {code, count_in, ts} is written at the detection edge.
  - evt_valid rises one cycle after detection when the FIFO was empty.
- FIFO:
  - Show-ahead: head fields are stable while evt_valid=1 and evt_ready=0.
  - A pop occurs on an edge where evt_valid=1 and evt_ready=1.
  - evt_level = entries stored, 0..DEPTH.
  - Pointers wrap modulo DEPTH.
  - Push and pop in the same cycle leave the level unchanged. This applies at every level, including full.
  - When full with no pop, the push is dropped and overflow sets.
  - When empty, a push with evt_ready=1 still takes one cycle before the record is visible. There is no bypass.
- Overflow:
  - clear_ovf=1 clears overflow on the next edge.
  - If a drop and clear_ovf occur on the same edge, set wins and overflow=1.
- Invariants:
  - evt_valid = (evt_level != 0).
  - When evt_valid=0, the head fields hold their last values and are don't-care.
- Latency: 1 clock from the cycle an event condition is visible on the inputs to the record being available at the head, when the FIFO is empty.

Test Plan:
- Reset release, then enable_in=1 at cycle 2 with count_in=0 (counter model incrementing on enable) -> record {START, count 0, time 2}; evt_valid=1 at cycle 3.
- Enable held for 17 cycles from count 0 with evt_ready=1 -> WRAP record {WRAP, count 0}; its time is exactly 16 after the START time.
- Enable=1 but count_in held at 5 for one cycle -> single {ERROR, count 5}. Enable=0 with count_in changing 7->8 -> {ERROR, count 8}.
- Enable falls on the same edge count wraps 15->0 -> only {WRAP, count 0} is recorded; no STOP record.
- evt_ready=0 and five events generated -> evt_level=4, overflow=1, and the head is the first event. Then clear_ovf=1 together with a sixth event -> overflow stays 1. Drain with evt_ready=1 -> records pop in order and evt_level reaches 0.
- FIFO holding 2 records, rst pulled low mid-cycle -> evt_valid=0, evt_level=0 and overflow=0 before the next edge. After release, no event is detected in the first cycle even if count_in differs from its pre-reset value.
